// File: rtl/usb_line_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_line_monitor_pkg
// Description : Shared line-state encoding and pin decode helper for the
//               USB line monitor (same encoding as the combinational
//               usb_line_decoder).
// Revision    : 1.0 - initial clocked line monitor release
// ============================================================================
package usb_line_monitor_pkg;

  // Line-state encoding shared with the combinational decoder
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_e;

  // Map {D+,D-} to a line state; low-speed swaps the J/K meaning of the
  // differential states, the single-ended states are polarity independent.
  function automatic line_state_e decode_line(input logic dp,
                                              input logic dn,
                                              input logic low_speed);
    line_state_e st;
    case ({dp, dn})
      2'b00:   st = LS_SE0;
      2'b11:   st = LS_SE1;
      2'b10:   st = low_speed ? LS_K : LS_J;
      default: st = low_speed ? LS_J : LS_K;
    endcase
    return st;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_pin_sync.sv
`default_nettype none
// ============================================================================
// Module      : usb_pin_sync
// Description : Multi-flop synchroniser bringing one asynchronous USB pin
//               into the clk domain. Resets to 0 so the line reads SE0.
// Revision    : 1.0 - initial clocked line monitor release
// ============================================================================
module usb_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  if (STAGES < 2) begin : g_chk_stages
    $error("usb_pin_sync: STAGES must be at least 2");
  end

  logic [STAGES-1:0] stages;

  // Shift the raw pin through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[STAGES-2:0], async_in};
    end
  end

  assign sync_out = stages[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/usb_line_monitor.sv
`default_nettype none
// ============================================================================
// Module      : usb_line_monitor
// Description : Synchronises D+/D-, deglitches the decoded line state and
//               times line-state durations to flag bus reset (long SE0),
//               suspend (long idle J) and resume (K while suspended).
// Revision    : 1.0 - initial clocked line monitor release
// ============================================================================
module usb_line_monitor #(
  parameter int SYNC_STAGES         = 2,
  parameter int FILTER_CYCLES       = 4,
  parameter int SE0_RESET_CYCLES    = 120,
  parameter int IDLE_SUSPEND_CYCLES = 144000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       usb_dp,
  input  logic       usb_dn,
  input  logic       low_speed,
  output logic [1:0] usb_line_state,
  output logic       state_change,
  output logic       bus_reset,
  output logic       bus_reset_pulse,
  output logic       suspend,
  output logic       resume_pulse
);

  import usb_line_monitor_pkg::*;

  localparam int CNT_W  = $clog2(IDLE_SUSPEND_CYCLES + 1);
  localparam int FCNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  localparam logic [FCNT_W-1:0] FCNT_MAX  = FCNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DCNT_MAX  = CNT_W'(IDLE_SUSPEND_CYCLES);
  localparam logic [CNT_W-1:0]  RESET_THR = CNT_W'(SE0_RESET_CYCLES);

  if (FILTER_CYCLES < 1) begin : g_chk_filter
    $error("usb_line_monitor: FILTER_CYCLES must be at least 1");
  end
  if (IDLE_SUSPEND_CYCLES <= SE0_RESET_CYCLES) begin : g_chk_timing
    $error("usb_line_monitor: IDLE_SUSPEND_CYCLES must exceed SE0_RESET_CYCLES");
  end

  // --------------------------------------------------------------------------
  // Pin synchronisers
  // --------------------------------------------------------------------------
  logic dp_sync;
  logic dn_sync;

  usb_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (usb_dp),
    .sync_out (dp_sync)
  );

  usb_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_dn (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (usb_dn),
    .sync_out (dn_sync)
  );

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  line_state_e       candidate;
  line_state_e       line_state;
  logic [FCNT_W-1:0] fcnt;
  logic [CNT_W-1:0]  dcnt;

  // --------------------------------------------------------------------------
  // Next-state values. The acceptance decision looks at the updated filter
  // count so that a change lands exactly SYNC_STAGES+FILTER_CYCLES clocks
  // after the pin edge; the flags are likewise derived from the updated
  // line state and duration so they track state_change on the same clock.
  // --------------------------------------------------------------------------
  line_state_e       raw_state;
  line_state_e       next_candidate;
  line_state_e       next_line;
  logic [FCNT_W-1:0] next_fcnt;
  logic [CNT_W-1:0]  next_dcnt;
  logic              accept;
  logic              next_bus_reset;
  logic              next_suspend;
  logic              next_resume;

  // Decode, deglitch filter and duration/flag next-state logic
  always_comb begin
    raw_state      = decode_line(dp_sync, dn_sync, low_speed);
    next_candidate = candidate;
    next_fcnt      = fcnt;
    next_line      = line_state;
    next_dcnt      = dcnt;

    // Any disagreement with the candidate (including a low_speed toggle
    // re-mapping J/K) restarts the stability count.
    if (candidate != raw_state) begin
      next_candidate = raw_state;
      next_fcnt      = '0;
    end else if (fcnt != FCNT_MAX) begin
      next_fcnt = fcnt + FCNT_W'(1);
    end

    accept = (next_fcnt == FCNT_MAX) && (next_candidate != line_state);

    if (accept) begin
      next_line = next_candidate;
      next_dcnt = '0;
    end else if (dcnt != DCNT_MAX) begin
      next_dcnt = dcnt + CNT_W'(1);
    end

    // SE1 is an ordinary state: it never qualifies for either flag
    next_bus_reset = (next_line == LS_SE0) && (next_dcnt >= RESET_THR);
    next_suspend   = !accept &&
                     (suspend || ((next_line == LS_J) && (next_dcnt == DCNT_MAX)));
    next_resume    = accept && suspend && (next_candidate == LS_K);
  end

  // Filter state, accepted line state and duration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      candidate  <= LS_SE0;
      fcnt       <= '0;
      line_state <= LS_SE0;
      dcnt       <= '0;
    end else begin
      candidate  <= next_candidate;
      fcnt       <= next_fcnt;
      line_state <= next_line;
      dcnt       <= next_dcnt;
    end
  end

  // Registered event pulses and level flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_change    <= 1'b0;
      bus_reset       <= 1'b0;
      bus_reset_pulse <= 1'b0;
      suspend         <= 1'b0;
      resume_pulse    <= 1'b0;
    end else begin
      state_change    <= accept;
      bus_reset       <= next_bus_reset;
      bus_reset_pulse <= next_bus_reset && !bus_reset;
      suspend         <= next_suspend;
      resume_pulse    <= next_resume;
    end
  end

  assign usb_line_state = line_state;

endmodule
`default_nettype wire

// File: tb/tb_usb_line_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_line_monitor
// Description : Randomised scoreboard bench for usb_line_monitor. Stimulus
//               pushes expected outputs from a run-length reference model;
//               a monitor pops and compares one entry per clock.
// Revision    : 1.0 - initial clocked line monitor release
// ============================================================================
module tb_usb_line_monitor;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_CYCLES = 4;
  localparam int SE0_RESET_CYCLES = 20;
  localparam int IDLE_SUSPEND_CYCLES = 100;

  localparam logic [1:0] ST_SE0 = 2'b00;
  localparam logic [1:0] ST_J   = 2'b01;
  localparam logic [1:0] ST_K   = 2'b10;
  localparam logic [1:0] ST_SE1 = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       usb_dp = 1'b0;
  logic       usb_dn = 1'b0;
  logic       low_speed = 1'b0;
  logic [1:0] usb_line_state;
  logic       state_change;
  logic       bus_reset;
  logic       bus_reset_pulse;
  logic       suspend;
  logic       resume_pulse;

  usb_line_monitor #(
    .SYNC_STAGES         (SYNC_STAGES),
    .FILTER_CYCLES       (FILTER_CYCLES),
    .SE0_RESET_CYCLES    (SE0_RESET_CYCLES),
    .IDLE_SUSPEND_CYCLES (IDLE_SUSPEND_CYCLES)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .usb_dp          (usb_dp),
    .usb_dn          (usb_dn),
    .low_speed       (low_speed),
    .usb_line_state  (usb_line_state),
    .state_change    (state_change),
    .bus_reset       (bus_reset),
    .bus_reset_pulse (bus_reset_pulse),
    .suspend         (suspend),
    .resume_pulse    (resume_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] line;
    logic       sc;
    logic       br;
    logic       brp;
    logic       susp;
    logic       res;
  } exp_t;

  exp_t expq[$];
  int   tests   = 0;
  int   fails   = 0;
  int   cycle   = 0;
  bit   running = 0;

  // Reference model: pin delay line, run-length of the decoded value,
  // accepted state and time spent in it.
  logic [1:0] m_pipe[$];
  logic [1:0] m_run_val;
  int         m_run_len;
  logic [1:0] m_line;
  int         m_dur;
  bit         m_susp;
  bit         m_br;

  bit         want_rst = 1;
  bit         cur_ls = 0;

  function automatic logic [1:0] ref_decode(input logic [1:0] pins, input bit ls);
    if (pins == 2'b00) return ST_SE0;
    if (pins == 2'b11) return ST_SE1;
    if (pins == 2'b10) return ls ? ST_K : ST_J;
    return ls ? ST_J : ST_K;
  endfunction

  task automatic model_reset();
    m_pipe.delete();
    for (int i = 0; i < SYNC_STAGES; i++) m_pipe.push_back(2'b00);
    m_run_val = ST_SE0;
    m_run_len = 1;
    m_line    = ST_SE0;
    m_dur     = 0;
    m_susp    = 0;
    m_br      = 0;
  endtask

  task automatic model_step(input logic [1:0] pins, input bit ls, output exp_t e);
    logic [1:0] raw;
    bit acc, prev_susp, prev_br;
    raw = ref_decode(m_pipe.pop_front(), ls);
    m_pipe.push_back(pins);
    if (raw == m_run_val) m_run_len++;
    else begin
      m_run_val = raw;
      m_run_len = 1;
    end
    acc       = (m_run_len >= FILTER_CYCLES) && (m_run_val != m_line);
    prev_susp = m_susp;
    prev_br   = m_br;
    if (acc) begin
      m_line = m_run_val;
      m_dur  = 0;
    end else if (m_dur < IDLE_SUSPEND_CYCLES) begin
      m_dur++;
    end
    m_br   = (m_line == ST_SE0) && (m_dur >= SE0_RESET_CYCLES);
    m_susp = (m_line == ST_J) && (m_dur >= IDLE_SUSPEND_CYCLES);
    e.line = m_line;
    e.sc   = acc;
    e.br   = m_br;
    e.brp  = m_br && !prev_br;
    e.susp = m_susp;
    e.res  = acc && prev_susp && (m_line == ST_K);
  endtask

  // One clock of stimulus: drive at the falling edge, push the expectation
  // for the following rising edge.
  task automatic drive_cycle(input logic [1:0] pins);
    exp_t e;
    bit   entering_rst;
    @(negedge clk);
    entering_rst = want_rst && rst_n;
    rst_n     = !want_rst;
    usb_dp    = pins[1];
    usb_dn    = pins[0];
    low_speed = cur_ls;
    if (entering_rst) begin
      #1;
      tests++;
      if ({usb_line_state, state_change, bus_reset, bus_reset_pulse, suspend, resume_pulse} !== 7'b0) begin
        fails++;
        $display("FAIL async_reset t=%0t: got line=%b sc=%b br=%b brp=%b susp=%b res=%b, want all 0",
                 $time, usb_line_state, state_change, bus_reset, bus_reset_pulse, suspend, resume_pulse);
      end
    end
    if (want_rst) begin
      model_reset();
      e = '0;
    end else begin
      model_step(pins, cur_ls, e);
    end
    expq.push_back(e);
    running = 1;
  endtask

  task automatic hold(input logic [1:0] pins, input int n);
    for (int i = 0; i < n; i++) drive_cycle(pins);
  endtask

  function automatic logic [1:0] j_pins();
    return cur_ls ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] k_pins();
    return cur_ls ? 2'b10 : 2'b01;
  endfunction

  // Monitor: compare the DUT against the oldest expectation after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        tests++;
        if ({usb_line_state, state_change, bus_reset, bus_reset_pulse, suspend, resume_pulse} !== e) begin
          fails++;
          $display("FAIL outputs cycle %0d: got line=%b sc=%b br=%b brp=%b susp=%b res=%b, want line=%b sc=%b br=%b brp=%b susp=%b res=%b",
                   cycle, usb_line_state, state_change, bus_reset, bus_reset_pulse, suspend, resume_pulse,
                   e.line, e.sc, e.br, e.brp, e.susp, e.res);
        end
      end else if (running) begin
        tests++;
        fails++;
        $display("FAIL scoreboard cycle %0d: got empty queue, want one expectation", cycle);
      end
    end
  end

  // Stimulus: directed scenarios, then randomised segments
  initial begin
    int kind;
    int len;
    model_reset();

    // Reset held with idle J on the pins, then release
    want_rst = 1;
    hold(2'b10, 5);
    want_rst = 0;
    hold(2'b10, 12);

    // Glitch rejection: 3-clock K ignored, 4-clock K accepted
    hold(2'b01, 3);
    hold(2'b10, 10);
    hold(2'b01, 4);
    hold(2'b01, 6);
    hold(2'b10, 10);

    // Low-speed polarity swap
    cur_ls = 1;
    hold(2'b10, 10);
    hold(2'b01, 10);
    cur_ls = 0;
    hold(2'b10, 10);

    // Long SE0 -> bus reset, then J drops it
    hold(2'b00, 34);
    hold(2'b10, 10);

    // Suspend then resume by K; suspend then exit by SE0
    hold(2'b10, 110);
    hold(2'b01, 10);
    hold(2'b10, 110);
    hold(2'b00, 10);
    hold(2'b10, 10);

    // SE1 held long never raises a flag
    hold(2'b11, 130);
    hold(2'b10, 10);

    // Reset while suspended, and reset in the middle of filtering
    hold(2'b10, 110);
    want_rst = 1;
    hold(2'b10, 3);
    want_rst = 0;
    hold(2'b10, 10);
    hold(2'b01, 2);
    want_rst = 1;
    hold(2'b01, 2);
    want_rst = 0;
    hold(2'b10, 12);

    // Randomised segments
    for (int s = 0; s < 70; s++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2: hold(2'($urandom_range(0, 3)), $urandom_range(1, 5));
        3, 4:    hold(2'($urandom_range(0, 3)), $urandom_range(6, 30));
        5:       hold(2'b00, $urandom_range(18, 40));
        6:       hold(j_pins(), $urandom_range(95, 130));
        7:       hold(k_pins(), $urandom_range(3, 12));
        8: begin
          cur_ls = !cur_ls;
          hold(2'($urandom_range(1, 2)), $urandom_range(2, 10));
        end
        default: begin
          len = $urandom_range(1, 3);
          want_rst = 1;
          hold(2'($urandom_range(0, 3)), len);
          want_rst = 0;
          hold(j_pins(), 8);
        end
      endcase
    end

    // Drain the scoreboard with a bounded wait
    @(posedge clk);
    #2;
    if (expq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending expectations, want 0", expq.size());
    end
    running = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
